// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The scoreboard entry type is {valid, tag} at the default register width.
package hazard_pkg;

    localparam int unsigned DEFAULT_REG_AW = 5;
    localparam int unsigned ZERO_REG       = 0;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_REG_AW-1:0] tag;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_STALL
    } hz_action_t;

endpackage

// File: rtl/load_scoreboard.sv
// Shift register of in-flight load destinations (ages 1..LOAD_LAT-1) plus
// per-source match against those entries and the live EX load (age 0).
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = DEFAULT_REG_AW,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    output logic              rs_match,
    output logic              rt_match
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] tag;
    } entry_t;

    // Element 0 holds age 1; LOAD_LAT=1 keeps a single constant-empty slot.
    localparam int unsigned DEPTH = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

    entry_t sb_q [DEPTH];
    logic   rs_hit;
    logic   rt_hit;
    logic   age0_valid;

    generate
        if (LOAD_LAT > 1) begin : g_regs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        sb_q[k] <= '0;
                    end
                end else if (shift_en) begin
                    sb_q[0].valid <= ex_valid & ex_mem_read & (ex_rd != REG_AW'(ZERO_REG));
                    sb_q[0].tag   <= ex_rd;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        sb_q[k] <= sb_q[k-1];
                    end
                end
            end
        end else begin : g_none
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, shift_en};
            assign sb_q[0]   = '0;
        end
    endgenerate

    assign age0_valid = ex_valid & ex_mem_read;

    always_comb begin
        rs_hit = age0_valid & (ex_rd == rs_id);
        rt_hit = age0_valid & (ex_rd == rt_id);
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (sb_q[k].valid) begin
                rs_hit = rs_hit | (sb_q[k].tag == rs_id);
                rt_hit = rt_hit | (sb_q[k].tag == rt_id);
            end
        end
        rs_match = rs_hit & (rs_id != REG_AW'(ZERO_REG));
        rt_match = rt_hit & (rt_id != REG_AW'(ZERO_REG));
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: arbitrates memory freeze, taken-branch flush and
// load-use stall, and keeps a saturating count of load-use stall cycles.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = DEFAULT_REG_AW,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    logic       rs_match;
    logic       rt_match;
    logic       hz;
    logic       shift_en;
    hz_action_t action;

    assign shift_en = ~mem_busy;

    load_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (shift_en),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .rs_match    (rs_match),
        .rt_match    (rt_match)
    );

    assign hz = id_valid & ((rs_used & rs_match) | (rt_used & rt_match));

    always_comb begin
        action = ACT_RUN;
        if (mem_busy) begin
            action = ACT_FREEZE;
        end else if (branch_taken) begin
            action = ACT_FLUSH;
        end else if (hz) begin
            action = ACT_STALL;
        end
    end

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        case (action)
            ACT_FREEZE: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
            end
            ACT_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            ACT_STALL: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if ((action == ACT_STALL) && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit at load latencies 1, 2 and 3, plus a
// narrow-counter instance for saturation.
module tb_hazard_ctrl_unit;

    localparam logic [3:0] C_RUN    = 4'b1100;
    localparam logic [3:0] C_FREEZE = 4'b0000;
    localparam logic [3:0] C_FLUSH  = 4'b1111;
    localparam logic [3:0] C_STALL  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, rs_used, rt_used, ex_valid, ex_mem_read;
    logic       branch_taken, mem_busy, stat_clr;
    logic [4:0] rs_id, rt_id, ex_rd;

    logic        pc1, we1, fl1, bb1;
    logic        pc2, we2, fl2, bb2;
    logic        pc3, we3, fl3, bb3;
    logic        pcs, wes, fls, bbs;
    logic [15:0] cnt1, cnt2, cnt3;
    logic [2:0]  cnts;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used(rs_used), .rt_used(rt_used), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write_en(pc1), .ifid_write_en(we1), .ifid_flush(fl1), .idex_bubble(bb1),
        .stall_count(cnt1)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u_l2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used(rs_used), .rt_used(rt_used), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write_en(pc2), .ifid_write_en(we2), .ifid_flush(fl2), .idex_bubble(bb2),
        .stall_count(cnt2)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used(rs_used), .rt_used(rt_used), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write_en(pc3), .ifid_write_en(we3), .ifid_flush(fl3), .idex_bubble(bb3),
        .stall_count(cnt3)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used(rs_used), .rt_used(rt_used), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .pc_write_en(pcs), .ifid_write_en(wes), .ifid_flush(fls), .idex_bubble(bbs),
        .stall_count(cnts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        id_valid = 0; rs_used = 0; rt_used = 0; rs_id = 0; rt_id = 0;
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
        branch_taken = 0; mem_busy = 0; stat_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
    endtask

    task automatic ex_empty();
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("reset_ctrl_l1", 32'({pc1, we1, fl1, bb1}), 32'(C_RUN));
        check("reset_ctrl_l3", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        check("reset_cnt_l3", 32'(cnt3), 0);
        tick();
        rst_n = 1'b1;
        #1;

        // LOAD_LAT=1 single-cycle load-use stall on rs
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 5; rt_used = 1; rt_id = 2;
        load_in_ex(5);
        #1 check("l1_stall", 32'({pc1, we1, fl1, bb1}), 32'(C_STALL));
        tick();
        ex_empty();
        #1 check("l1_release", 32'({pc1, we1, fl1, bb1}), 32'(C_RUN));
        check("l1_cnt", 32'(cnt1), 1);

        // LOAD_LAT=3 stall on rt lasts three cycles
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 3; rt_used = 1; rt_id = 7;
        load_in_ex(7);
        #1 check("l3_stall_t0", 32'({pc3, we3, fl3, bb3}), 32'(C_STALL));
        tick();
        ex_empty();
        #1 check("l3_stall_t1", 32'({pc3, we3, fl3, bb3}), 32'(C_STALL));
        tick();
        check("l3_stall_t2", 32'({pc3, we3, fl3, bb3}), 32'(C_STALL));
        tick();
        check("l3_release_t3", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        check("l3_cnt", 32'(cnt3), 3);

        // Same sequence with rt_used=0 never stalls
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 3; rt_used = 0; rt_id = 7;
        load_in_ex(7);
        #1 check("l3_nouse_t0", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        tick();
        ex_empty();
        #1 check("l3_nouse_t1", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        tick();
        check("l3_nouse_cnt", 32'(cnt3), 0);

        // Load to $0 with ID reading $0
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 0; rt_used = 1; rt_id = 0;
        load_in_ex(0);
        #1 check("zero_l1", 32'({pc1, we1, fl1, bb1}), 32'(C_RUN));
        check("zero_l3", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        tick();
        ex_empty();
        #1 check("zero_l3_age1", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        check("zero_cnt_l3", 32'(cnt3), 0);

        // LOAD_LAT=2 stall interrupted by two busy cycles
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 9;
        load_in_ex(9);
        #1 check("l2_stall_t0", 32'({pc2, we2, fl2, bb2}), 32'(C_STALL));
        tick();
        ex_empty();
        mem_busy = 1;
        #1 check("l2_busy0", 32'({pc2, we2, fl2, bb2}), 32'(C_FREEZE));
        tick();
        check("l2_busy1", 32'({pc2, we2, fl2, bb2}), 32'(C_FREEZE));
        tick();
        mem_busy = 0;
        #1 check("l2_resume", 32'({pc2, we2, fl2, bb2}), 32'(C_STALL));
        tick();
        check("l2_release", 32'({pc2, we2, fl2, bb2}), 32'(C_RUN));
        check("l2_cnt", 32'(cnt2), 2);

        // Branch overrides a simultaneous hazard
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 5;
        load_in_ex(5);
        branch_taken = 1;
        #1 check("br_flush_l1", 32'({pc1, we1, fl1, bb1}), 32'(C_FLUSH));
        tick();
        check("br_cnt_l1", 32'(cnt1), 0);

        // Asynchronous reset in the middle of a LOAD_LAT=3 stall
        do_reset();
        id_valid = 1; rt_used = 1; rt_id = 7;
        load_in_ex(7);
        tick();
        ex_empty();
        #1 check("rst_pre_stall", 32'({pc3, we3, fl3, bb3}), 32'(C_STALL));
        check("rst_pre_cnt", 32'(cnt3), 1);
        rst_n = 1'b0;
        #1 check("rst_mid_ctrl", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        check("rst_mid_cnt", 32'(cnt3), 0);
        #1 rst_n = 1'b1;
        tick();
        check("rst_after_ctrl", 32'({pc3, we3, fl3, bb3}), 32'(C_RUN));
        check("rst_after_cnt", 32'(cnt3), 0);

        // Counter saturation and clear on a 3-bit counter
        do_reset();
        id_valid = 1; rs_used = 1; rs_id = 4;
        load_in_ex(4);
        for (int i = 0; i < 6; i++) tick();
        check("sat_cnt6", 32'(cnts), 6);
        for (int i = 0; i < 4; i++) tick();
        check("sat_hold", 32'(cnts), 7);
        check("sat_still_stall", 32'({pcs, wes, fls, bbs}), 32'(C_STALL));
        stat_clr = 1;
        tick();
        check("sat_clr", 32'(cnts), 0);
        stat_clr = 0;
        tick();
        check("sat_count_again", 32'(cnts), 1);

        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
